// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 ops,
// FSM states, ALU select codes and small op-decoding helpers.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [2:0] {
        MDU_IDLE = 3'd0,
        MDU_PREP = 3'd1,
        MDU_ITER = 3'd2,
        MDU_FIX  = 3'd3,
        MDU_DONE = 3'd4
    } mdu_state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_sel_t;

    // Divide family (DIV, DIVU, REM, REMU)
    function automatic logic is_div(mdu_op_t op);
        logic [2:0] f;
        f = op;
        return f[2];
    endfunction

    // Remainder outputs (REM, REMU)
    function automatic logic is_rem(mdu_op_t op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    // High-word multiply outputs (MULH, MULHSU, MULHU)
    function automatic logic hi_word(mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
    endfunction

    // rs1 is a signed operand. MUL returns only the low word, which does not
    // depend on signedness, so it runs on raw unsigned operands.
    function automatic logic op1_signed(mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // rs2 is a signed operand (MULHSU keeps rs2 unsigned)
    function automatic logic op2_signed(mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_alu.sv
// Single-adder integer ALU shared by the sequencer. c_flag is the adder
// carry-out: on ALU_SUB it is 1 when no borrow occurred (a >= b unsigned).
module muldiv_sequencer_alu
    import muldiv_sequencer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  alu_sel_t             sel,
    input  logic                 type_ir,
    input  logic [$clog2(W)-1:0] shamt,
    output logic [W-1:0]         y,
    output logic                 c_flag
);

    logic [W-1:0]         b_eff;
    logic [W:0]           sum;
    logic [$clog2(W)-1:0] sh;

    // One adder serves both add and subtract (a + ~b + 1)
    always_comb begin
        b_eff  = (sel == ALU_SUB) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, (sel == ALU_SUB)};
        c_flag = sum[W];
    end

    // Result select; immediate-form shifts take their amount from shamt
    always_comb begin
        sh = type_ir ? shamt : b[$clog2(W)-1:0];
        unique case (sel)
            ALU_ADD, ALU_SUB: y = sum[W-1:0];
            ALU_AND:          y = a & b;
            ALU_OR:           y = a | b;
            ALU_XOR:          y = a ^ b;
            ALU_SLL:          y = a << sh;
            ALU_SRL:          y = a >> sh;
            ALU_SRA:          y = $signed(a) >>> sh;
            default:          y = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV/REM sequencer. Shift-add multiply and restoring
// divide on operand magnitudes, driven through one shared ALU; the sign is
// applied in a final FIX cycle.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int n     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] rs1,
    input  logic [n-1:0] rs2,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    mdu_state_t       state;
    mdu_op_t          op;
    logic [n-1:0]     op_a;     // raw rs1 until PREP
    logic [n-1:0]     opb;      // |rs2| after accept, then multiplicand / divisor
    logic [n-1:0]     acc;      // product high word / partial remainder
    logic [n-1:0]     lo;       // multiplier -> product low word / quotient
    logic             sgn2;     // rs2 was a negative signed operand
    logic             neg_res;  // selected output must be negated in FIX
    logic [CNT_W-1:0] cnt;

    alu_sel_t         alu_sel;
    logic [n-1:0]     alu_a, alu_b, alu_y;
    logic             alu_c;

    mdu_op_t          in_op;
    logic             in_neg2;
    logic             s1;
    logic [n-1:0]     mag1;
    logic [n-1:0]     rem_sh;
    logic             take;
    logic             mul_c;
    logic [n-1:0]     mul_sum;
    logic [n-1:0]     fix_raw;
    logic             div_ovf;

    muldiv_sequencer_alu #(.W(n)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .sel    (alu_sel),
        .type_ir(1'b0),
        .shamt  ('0),
        .y      (alu_y),
        .c_flag (alu_c)
    );

    // Operand decode and per-step datapath terms
    always_comb begin
        in_op   = mdu_op_t'(funct3);
        in_neg2 = op2_signed(in_op) & rs2[n-1];
        s1      = op1_signed(op) & op_a[n-1];
        mag1    = s1 ? alu_y : op_a;
        rem_sh  = {acc[n-2:0], lo[n-1]};
        // The bit shifted out of rem is an implicit bit n: when set the
        // shifted remainder exceeds any divisor, so the trial always succeeds.
        take    = alu_c | acc[n-1];
        mul_c   = lo[0] & alu_c;
        mul_sum = lo[0] ? alu_y : acc;
        fix_raw = (hi_word(op) || is_rem(op)) ? acc : lo;
        div_ovf = is_div(op) && op1_signed(op) && sgn2 &&
                  (op_a == {1'b1, {(n-1){1'b0}}}) && (opb == n'(1));
    end

    // ALU operand mux: negate rs2 on accept, rs1 in PREP, step in ITER, sign in FIX
    always_comb begin
        alu_a   = '0;
        alu_b   = rs2;
        alu_sel = ALU_SUB;
        unique case (state)
            MDU_PREP: alu_b = op_a;
            MDU_ITER: begin
                if (is_div(op)) begin
                    alu_a   = rem_sh;
                    alu_b   = opb;
                    alu_sel = ALU_SUB;
                end else begin
                    alu_a   = acc;
                    alu_b   = opb;
                    alu_sel = ALU_ADD;
                end
            end
            MDU_FIX: begin
                if (hi_word(op)) begin
                    // high word of -{acc,lo} = ~acc + (lo == 0)
                    alu_a   = ~acc;
                    alu_b   = {{(n-1){1'b0}}, (lo == '0)};
                    alu_sel = ALU_ADD;
                end else begin
                    alu_b   = fix_raw;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MDU_IDLE;
            op      <= MDU_MUL;
            op_a    <= '0;
            opb     <= '0;
            acc     <= '0;
            lo      <= '0;
            sgn2    <= 1'b0;
            neg_res <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                MDU_IDLE, MDU_DONE: begin
                    if (start) begin
                        op    <= in_op;
                        op_a  <= rs1;
                        sgn2  <= in_neg2;
                        opb   <= in_neg2 ? alu_y : rs2;
                        busy  <= 1'b1;
                        state <= MDU_PREP;
                    end else begin
                        state <= MDU_IDLE;
                    end
                end
                MDU_PREP: begin
                    if (is_div(op) && opb == '0) begin
                        result <= is_rem(op) ? op_a : '1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= MDU_DONE;
                    end else if (div_ovf) begin
                        result <= is_rem(op) ? '0 : op_a;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= MDU_DONE;
                    end else begin
                        acc     <= '0;
                        cnt     <= CNT_W'(n);
                        neg_res <= is_rem(op) ? s1 : (s1 ^ sgn2);
                        if (is_div(op)) begin
                            lo <= mag1;
                        end else begin
                            lo  <= opb;
                            opb <= mag1;
                        end
                        state <= MDU_ITER;
                    end
                end
                MDU_ITER: begin
                    if (is_div(op)) begin
                        acc <= take ? alu_y : rem_sh;
                        lo  <= {lo[n-2:0], take};
                    end else begin
                        acc <= {mul_c, mul_sum[n-1:1]};
                        lo  <= {mul_sum[0], lo[n-1:1]};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= MDU_FIX;
                end
                MDU_FIX: begin
                    result <= neg_res ? alu_y : fix_raw;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= MDU_DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MDU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random RV32M ops
// against an arithmetic reference, plus flush, reset and back-to-back cases.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.n(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .funct3(funct3),
        .rs1   (rs1),
        .rs2   (rs2),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M semantics from 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Divide-by-zero and signed overflow resolve early
    function automatic int ref_latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op[2] && b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Issue one op, scramble inputs while busy, wait for done (bounded)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got, output int lat, output logic busy_ok);
        lat     = -1;
        got     = 'x;
        busy_ok = 1'b1;
        @(negedge clk);
        funct3 = op; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
        for (int k = 1; k <= 45; k++) begin
            if (done) begin
                lat = k;
                got = result;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] got, exp;
        int lat, elat;
        logic bok;
        exp  = ref_model(op, a, b);
        elat = ref_latency(op, a, b);
        run_op(op, a, b, got, lat, bok);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s result op=%0d a=%h b=%h got=%h exp=%h", name, op, a, b, got, exp);
        end
        total++;
        if (lat !== elat) begin
            bad++;
            $display("FAIL %s latency op=%0d got=%0d exp=%0d", name, op, lat, elat);
        end
        total++;
        if (bok !== 1'b1) begin
            bad++;
            $display("FAIL %s busy profile op=%0d got=0 exp=1", name, op);
        end
    endtask

    task automatic test_reset;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b result=%h exp 0/0/0", busy, done, result);
        end
    endtask

    task automatic test_directed;
        check_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD);
        check_op("mulhu_ones",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        check_op("mulh_ones",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        check_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2);
        check_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2);
        check_op("divu_5_0",    3'd5, 32'd5,          32'd0);
        check_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
        check_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        check_op("rem_0",       3'd6, 32'h1234_5678,  32'd0);
        check_op("mulhsu_neg",  3'd2, 32'hFFFF_FFFE,  32'hFFFF_FFFF);
        check_op("mul_zero",    3'd0, 32'd0,          32'hDEAD_BEEF);
        check_op("divu_big",    3'd5, 32'hFFFF_FFFF,  32'h8000_0001);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            check_op("random", op, a, b);
        end
    endtask

    task automatic test_flush;
        logic seen;
        check_op("pre_flush", 3'd5, 32'd100, 32'd7);
        @(negedge clk);
        funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
            bad++;
            $display("FAIL flush busy=%b done=%b result=%h exp 0/0/0000000e", busy, done, result);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || result !== 32'd14) begin
            bad++;
            $display("FAIL flush_no_done seen=%b result=%h exp 0/0000000e", seen, result);
        end
        check_op("post_flush", 3'd5, 32'd1000, 32'd3);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid busy=%b done=%b result=%h exp 0/0/0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        int ndone;
        logic seen;
        exp   = ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        ndone = 0;
        @(negedge clk);
        funct3 = 3'd3; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 105; k++) begin
            @(negedge clk);
            if (done) begin
                total++;
                if (k != 35 * (ndone + 1) || result !== exp) begin
                    bad++;
                    $display("FAIL b2b done#%0d cycle=%0d exp=%0d result=%h exp=%h",
                             ndone, k, 35 * (ndone + 1), result, exp);
                end
                ndone++;
            end
        end
        start = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (ndone != 3 || seen !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count got=%0d extra=%b exp=3 extra=0", ndone, seen);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; rs1 = 32'h0; rs2 = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
